mul_sequencer: RTL and testbench



---
 rtl/mul_sequencer_pkg.sv | 28 ++
 rtl/mul_step_dp.sv | 65 ++++++
 rtl/mul_sequencer.sv | 148 ++++++++++++++
 tb/tb_mul_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the iterative multiplier: FSM encodings,
// MUL instruction detection constants and flag bit positions.
package mul_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // MUL/MULS decode pattern: Instr[27:22] and Instr[7:4]
   localparam logic [5:0] MUL_OP_HI    = 6'b000000;
   localparam logic [3:0] MUL_OP_LO    = 4'b1001;

   // Position of N and Z inside the NZCV flag nibble
   localparam int unsigned FLAG_N_IDX  = 3;
   localparam int unsigned FLAG_Z_IDX  = 2;

   // True when the instruction word encodes a MUL/MULS
   function automatic logic is_mul_instr(input logic [31:0] instr);
      logic [5:0] hi;
      logic [3:0] lo;
      hi = instr[27:22];
      lo = instr[7:4];
      return (hi == MUL_OP_HI) && (lo == MUL_OP_LO);
   endfunction

endpackage

// File: rtl/mul_step_dp.sv
// Shift-add datapath: multiplicand/multiplier shift registers,
// accumulator adder and iteration counter, driven by load/step enables.
module mul_step_dp
   import mul_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_b,
   output logic [CNT_W-1:0] o_cnt,
   output logic [WIDTH-1:0] o_acc_nxt
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] w_addend;

   // Partial product for this step: A when the current multiplier bit is set
   always_comb begin
      w_addend = '0;
      if (r_b[0]) begin
         w_addend = r_a;
      end else begin
         w_addend = '0;
      end
   end

   assign o_acc_nxt = r_acc + w_addend;
   assign o_b       = r_b;
   assign o_cnt     = r_cnt;

   // Load operands on accept, otherwise advance one shift-add iteration per step
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_step) begin
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
         r_acc <= o_acc_nxt;
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_a   <= r_a;
         r_b   <= r_b;
         r_acc <= r_acc;
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative multiplier sequencer: accepts a condition-qualified MUL request,
// runs the shift-add datapath, and returns the low product word, NZ flags
// and a stall that holds the PC/IR while the iteration is in progress.
module mul_sequencer
   import mul_sequencer_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int EARLY_OUT = 1,
   parameter int CNT_W     = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic             SetFlags,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [WIDTH-1:0] Product,
   output logic             Done,
   output logic             Busy,
   output logic             Stall,
   output logic [1:0]       FlagsOut,
   output logic             FlagWrite
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_step;
   logic             w_set_flags_eff;
   logic [WIDTH-1:0] w_product_nxt;
   logic [WIDTH-1:0] w_b;
   logic [CNT_W-1:0] w_cnt;
   logic [WIDTH-1:0] w_acc_nxt;

   logic [WIDTH-1:0] r_product;
   logic             r_done;
   logic             r_busy;
   logic [1:0]       r_flags;
   logic             r_flag_write;
   logic             r_set_flags;

   mul_step_dp #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_dp (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_a       (SrcA),
      .i_b       (SrcB),
      .o_b       (w_b),
      .o_cnt     (w_cnt),
      .o_acc_nxt (w_acc_nxt)
   );

   // Next-state and datapath enables; DONE accepts a new request like IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               w_load = 1'b1;
               if ((EARLY_OUT != 0) && (SrcB == '0)) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if ((w_cnt == CNT_W'(WIDTH-1)) ||
                ((EARLY_OUT != 0) && ((w_b >> 1) == '0))) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Value and S-bit captured on DONE entry; a zero multiplier bypasses RUN
   always_comb begin
      w_product_nxt   = '0;
      w_set_flags_eff = 1'b0;
      if (w_load) begin
         w_product_nxt   = '0;
         w_set_flags_eff = SetFlags;
      end else begin
         w_product_nxt   = w_acc_nxt;
         w_set_flags_eff = r_set_flags;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered result, flags and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_product    <= '0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_flags      <= 2'b00;
         r_flag_write <= 1'b0;
         r_set_flags  <= 1'b0;
      end else begin
         r_done       <= (w_state_nxt == ST_DONE);
         r_busy       <= (w_state_nxt == ST_RUN);
         r_flag_write <= (w_state_nxt == ST_DONE) && w_set_flags_eff;
         if (w_load) begin
            r_set_flags <= SetFlags;
         end else begin
            r_set_flags <= r_set_flags;
         end
         if (w_state_nxt == ST_DONE) begin
            r_product <= w_product_nxt;
            r_flags   <= {w_product_nxt[WIDTH-1], (w_product_nxt == '0)};
         end else begin
            r_product <= r_product;
            r_flags   <= r_flags;
         end
      end
   end

   assign Product   = r_product;
   assign Done      = r_done;
   assign Busy      = r_busy;
   assign FlagsOut  = r_flags;
   assign FlagWrite = r_flag_write;
   // Stall is combinational on Start so the PC freezes in the accept cycle
   assign Stall     = ((r_state == ST_IDLE) && Start) || (r_state == ST_RUN);

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: one instance without early-out and one
// with early-out, each driven by its own stimulus signals.
module tb_mul_sequencer;

   logic        clk;
   // instance without early-out
   logic        rst0, start0, sf0;
   logic [31:0] a0, b0, prod0;
   logic        done0, busy0, stall0, fw0;
   logic [1:0]  fl0;
   // instance with early-out
   logic        rst1, start1, sf1;
   logic [31:0] a1, b1, prod1;
   logic        done1, busy1, stall1, fw1;
   logic [1:0]  fl1;

   int checks   = 0;
   int failures = 0;

   mul_sequencer #(.WIDTH(32), .EARLY_OUT(0), .CNT_W(5)) u_dut0 (
      .clk(clk), .reset(rst0), .Start(start0), .SetFlags(sf0),
      .SrcA(a0), .SrcB(b0), .Product(prod0), .Done(done0), .Busy(busy0),
      .Stall(stall0), .FlagsOut(fl0), .FlagWrite(fw0)
   );

   mul_sequencer #(.WIDTH(32), .EARLY_OUT(1), .CNT_W(5)) u_dut1 (
      .clk(clk), .reset(rst1), .Start(start1), .SetFlags(sf1),
      .SrcA(a1), .SrcB(b1), .Product(prod1), .Done(done1), .Busy(busy1),
      .Stall(stall1), .FlagsOut(fl1), .FlagWrite(fw1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Instance 0: tick from the accept edge until Done; Start dropped after tick 1
   task automatic wait_done0(output int cyc, output int busy_n, output int stall_err);
      cyc = 0; busy_n = 0; stall_err = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         start0 = 1'b0;
         if (done0) begin
            cyc = i;
            break;
         end
         if (busy0) busy_n++;
         if (stall0 !== busy0) stall_err++;
      end
   endtask

   // Instance 1: optional Start hold, optional one-cycle Start pulse with junk operands
   task automatic wait_done1(input bit hold, input int pulse_at,
                             output int cyc, output int busy_n, output int stall_err);
      cyc = 0; busy_n = 0; stall_err = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (!hold) begin
            start1 = (i == pulse_at);
            if (i == pulse_at) begin
               a1 = 32'd5;
               b1 = 32'd5;
            end
         end
         if (done1) begin
            cyc = i;
            break;
         end
         if (busy1) busy_n++;
         if (stall1 !== busy1) stall_err++;
      end
   endtask

   int cyc, bn, se;

   initial begin
      rst0 = 1'b1; start0 = 1'b0; sf0 = 1'b0; a0 = 32'd0; b0 = 32'd0;
      rst1 = 1'b1; start1 = 1'b0; sf1 = 1'b0; a1 = 32'd0; b1 = 32'd0;
      tick(); tick();
      rst0 = 1'b0; rst1 = 1'b0;
      tick();

      // reset state
      chk("rst_prod", prod0, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_stall", {31'd0, stall0}, 32'd0);
      chk("rst_flags", {30'd0, fl0}, 32'd0);
      chk("rst_fw", {31'd0, fw1}, 32'd0);

      // T1: no early-out, 3*5
      start0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
      #1;
      chk("t1_stall_accept", {31'd0, stall0}, 32'd1);
      wait_done0(cyc, bn, se);
      chk("t1_done_cyc", cyc, 32'd33);
      chk("t1_busy_n", bn, 32'd32);
      chk("t1_stall_run", se, 32'd0);
      chk("t1_prod", prod0, 32'd15);
      chk("t1_flags", {30'd0, fl0}, 32'd0);
      chk("t1_stall_done", {31'd0, stall0}, 32'd0);
      chk("t1_busy_done", {31'd0, busy0}, 32'd0);
      tick();
      chk("t1_done_pulse", {31'd0, done0}, 32'd0);

      // T2: early-out, 0xFFFFFFFE*3 with S bit
      start1 = 1'b1; sf1 = 1'b1; a1 = 32'hFFFF_FFFE; b1 = 32'd3;
      wait_done1(1'b0, 0, cyc, bn, se);
      sf1 = 1'b0;
      chk("t2_done_cyc", cyc, 32'd3);
      chk("t2_prod", prod1, 32'hFFFF_FFFA);
      chk("t2_flags", {30'd0, fl1}, 32'd2);
      chk("t2_fw", {31'd0, fw1}, 32'd1);
      tick();
      chk("t2_fw_pulse", {31'd0, fw1}, 32'd0);

      // T3: early-out with zero multiplier
      start1 = 1'b1; a1 = 32'd7; b1 = 32'd0;
      wait_done1(1'b0, 0, cyc, bn, se);
      chk("t3_done_cyc", cyc, 32'd1);
      chk("t3_busy_n", bn, 32'd0);
      chk("t3_busy", {31'd0, busy1}, 32'd0);
      chk("t3_prod", prod1, 32'd0);
      chk("t3_flags", {30'd0, fl1}, 32'd1);
      chk("t3_fw", {31'd0, fw1}, 32'd0);
      tick();

      // T4: all-ones squared, Start pulse at RUN cycle 10 is ignored
      start1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
      wait_done1(1'b0, 10, cyc, bn, se);
      chk("t4_done_cyc", cyc, 32'd33);
      chk("t4_busy_n", bn, 32'd32);
      chk("t4_prod", prod1, 32'd1);
      chk("t4_flags", {30'd0, fl1}, 32'd0);
      tick();
      chk("t4_idle_after", {31'd0, busy1}, 32'd0);

      // T5: 6*7 then back-to-back 2*4 with Start held through DONE
      start1 = 1'b1; a1 = 32'd6; b1 = 32'd7;
      tick();
      a1 = 32'd2; b1 = 32'd4;
      wait_done1(1'b1, 0, cyc, bn, se);
      chk("t5a_done_cyc", cyc, 32'd3);
      chk("t5a_prod", prod1, 32'd42);
      chk("t5a_stall_done", {31'd0, stall1}, 32'd0);
      wait_done1(1'b0, 0, cyc, bn, se);
      chk("t5b_done_cyc", cyc, 32'd4);
      chk("t5b_busy_n", bn, 32'd3);
      chk("t5b_prod", prod1, 32'd8);
      tick();

      // T6: reset at RUN cycle 5 of 9*9 aborts, then 2*2 completes
      start0 = 1'b1; a0 = 32'd9; b0 = 32'd9;
      for (int i = 1; i <= 5; i++) begin
         tick();
         start0 = 1'b0;
      end
      chk("t6_busy_pre", {31'd0, busy0}, 32'd1);
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      chk("t6_busy_rst", {31'd0, busy0}, 32'd0);
      chk("t6_prod_rst", prod0, 32'd0);
      chk("t6_done_rst", {31'd0, done0}, 32'd0);
      chk("t6_stall_rst", {31'd0, stall0}, 32'd0);
      tick();
      chk("t6_done_idle", {31'd0, done0}, 32'd0);
      start0 = 1'b1; a0 = 32'd2; b0 = 32'd2;
      wait_done0(cyc, bn, se);
      chk("t6_done_cyc", cyc, 32'd33);
      chk("t6_prod", prod0, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
